// File: rtl/rpn_stack_ctrl.sv
// RPN operand stack with a one-cycle ALU execute step; commands are push > op_go > pop.
// All outputs are registered; error flags are sticky until the next accepted command.
module rpn_stack_ctrl #(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BITS-1:0]            operand,
    input  logic                       push,
    input  logic                       op_go,
    input  logic [1:0]                 op_sel,
    input  logic                       pop,
    output logic [BITS-1:0]            top,
    output logic [BITS-1:0]            second,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err,
    output logic                       arith_err,
    output logic [3:0]                 state_num
);
    localparam int DW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   stk_q [DEPTH];
    logic [BITS-1:0]   stk_d [DEPTH];
    logic [DW-1:0]     depth_q, depth_d;
    logic [BITS-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, ari_q, ari_d;
    logic [BITS-1:0]   top_q, top_d, second_q, second_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic [3:0]        state_num_q, state_num_d;
    logic [BITS-1:0]   cur_top, cur_second, res;
    logic [BITS:0]     wide;
    logic              res_err;

    always_comb begin
        cur_top    = '0;
        cur_second = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(depth_q) - 1) cur_top = stk_q[i];
            if (i == int'(depth_q) - 2) cur_second = stk_q[i];
        end

        // Borrow/carry both land in the extra MSB of the widened result.
        wide = '0;
        unique case (op_q)
            2'b00:   wide = {1'b0, a_q} + {1'b0, b_q};
            2'b01:   wide = {1'b0, a_q} - {1'b0, b_q};
            2'b10:   wide = {1'b0, a_q & b_q};
            default: wide = {1'b0, a_q | b_q};
        endcase
        res     = wide[BITS-1:0];
        res_err = wide[BITS] && !op_q[1];

        state_d = state_q;
        depth_d = depth_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ari_d   = ari_q;
        for (int i = 0; i < DEPTH; i++) stk_d[i] = stk_q[i];

        if (state_q == S_EXEC) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(depth_q) - 2) stk_d[i] = res;
                if (i == int'(depth_q) - 1) stk_d[i] = '0;
            end
            depth_d = depth_q - DW'(1);
            ari_d   = res_err;
            state_d = res_err ? S_ERR : S_IDLE;
        end else if (push) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            ari_d = 1'b0;
            if (depth_q == DW'(DEPTH)) begin
                ovf_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (i == int'(depth_q)) stk_d[i] = operand;
                depth_d = depth_q + DW'(1);
                state_d = S_IDLE;
            end
        end else if (op_go) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            ari_d = 1'b0;
            if (depth_q < DW'(2)) begin
                unf_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                a_d     = cur_second;
                b_d     = cur_top;
                op_d    = op_sel;
                state_d = S_EXEC;
            end
        end else if (pop) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            ari_d = 1'b0;
            if (depth_q == '0) begin
                unf_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (i == int'(depth_q) - 1) stk_d[i] = '0;
                depth_d = depth_q - DW'(1);
                state_d = S_IDLE;
            end
        end

        // Display outputs are computed from next-state so they register with it.
        top_d    = '0;
        second_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(depth_d) - 1) top_d = stk_d[i];
            if (i == int'(depth_d) - 2) second_d = stk_d[i];
        end
        full_d  = (depth_d == DW'(DEPTH));
        empty_d = (depth_d == '0);
        unique case (state_d)
            S_EXEC:  state_num_d = 4'd1;
            S_ERR:   state_num_d = 4'd2;
            default: state_num_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ari_q       <= 1'b0;
            top_q       <= '0;
            second_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            state_num_q <= 4'd0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ari_q       <= ari_d;
            top_q       <= top_d;
            second_q    <= second_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            state_num_q <= state_num_d;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_d[i];
        end
    end

    assign top       = top_q;
    assign second    = second_q;
    assign depth     = depth_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
    assign arith_err = ari_q;
    assign state_num = state_num_q;
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl: a queue-based stack model predicts each command's outcome.
module tb_rpn_stack_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] operand;
    logic        push, op_go, pop;
    logic [1:0]  op_sel;
    logic [15:0] top, second;
    logic [2:0]  depth;
    logic        full, empty, ovf_err, unf_err, arith_err;
    logic [3:0]  state_num;

    rpn_stack_ctrl #(.BITS(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .operand(operand), .push(push), .op_go(op_go),
        .op_sel(op_sel), .pop(pop), .top(top), .second(second), .depth(depth),
        .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
        .arith_err(arith_err), .state_num(state_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] top;
        logic [15:0] second;
        logic [2:0]  depth;
        logic        full, empty, ovf, unf, ari;
        logic [3:0]  sn;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mstk[$];
    logic        m_ovf, m_unf, m_ari;
    logic [3:0]  m_sn;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_expect();
        exp_t e;
        e.top    = (mstk.size() >= 1) ? mstk[mstk.size()-1] : 16'h0;
        e.second = (mstk.size() >= 2) ? mstk[mstk.size()-2] : 16'h0;
        e.depth  = 3'(mstk.size());
        e.full   = (mstk.size() == 4);
        e.empty  = (mstk.size() == 0);
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.ari    = m_ari;
        e.sn     = m_sn;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".top"},    32'(top),       32'(e.top));
        chk({tag, ".second"}, 32'(second),    32'(e.second));
        chk({tag, ".depth"},  32'(depth),     32'(e.depth));
        chk({tag, ".full"},   32'(full),      32'(e.full));
        chk({tag, ".empty"},  32'(empty),     32'(e.empty));
        chk({tag, ".ovf"},    32'(ovf_err),   32'(e.ovf));
        chk({tag, ".unf"},    32'(unf_err),   32'(e.unf));
        chk({tag, ".ari"},    32'(arith_err), 32'(e.ari));
        chk({tag, ".state"},  32'(state_num), 32'(e.sn));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mstk.delete();
        m_ovf = 0; m_unf = 0; m_ari = 0; m_sn = 0;
        model_expect();
        compare(tag);
    endtask

    // Drive one command cycle; poke_exec additionally fires push/pop/op_go during EXEC.
    task automatic cmd(input string tag, input logic p, input logic o, input logic q,
                       input logic [1:0] sel, input logic [15:0] v, input logic poke_exec);
        logic        exec;
        logic [15:0] a, b;
        logic [16:0] w;
        exec = 1'b0;
        @(negedge clk);
        push = p; op_go = o; pop = q; op_sel = sel; operand = v;
        if (p) begin
            m_ovf = 0; m_unf = 0; m_ari = 0; m_sn = 0;
            if (mstk.size() == 4) begin m_ovf = 1; m_sn = 2; end
            else mstk.push_back(v);
        end else if (o) begin
            m_ovf = 0; m_unf = 0; m_ari = 0; m_sn = 0;
            if (mstk.size() < 2) begin m_unf = 1; m_sn = 2; end
            else begin
                exec = 1'b1;
                b = mstk.pop_back();
                a = mstk.pop_back();
                case (sel)
                    2'b00: begin w = 17'(a) + 17'(b); m_ari = w[16]; end
                    2'b01: begin w = 17'(a) - 17'(b); m_ari = (a < b); end
                    2'b10: w = 17'(a & b);
                    default: w = 17'(a | b);
                endcase
                mstk.push_back(w[15:0]);
                if (m_ari) m_sn = 2;
            end
        end else if (q) begin
            m_ovf = 0; m_unf = 0; m_ari = 0; m_sn = 0;
            if (mstk.size() == 0) begin m_unf = 1; m_sn = 2; end
            else void'(mstk.pop_back());
        end
        model_expect();
        @(posedge clk);
        #1;
        push = 0; op_go = 0; pop = 0;
        if (exec) begin
            chk({tag, ".exec_state"}, 32'(state_num), 32'd1);
            if (poke_exec) begin
                push = 1; op_go = 1; pop = 1; operand = 16'hAAAA;
            end
            @(posedge clk);
            #1;
            push = 0; op_go = 0; pop = 0;
        end
        compare(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; push = 0; op_go = 0; pop = 0; op_sel = 0; operand = 0;
        m_ovf = 0; m_unf = 0; m_ari = 0; m_sn = 0;
        #12;
        model_expect();
        compare("reset");
        rst = 1'b0;

        // Add, no carry
        cmd("p5",   1, 0, 0, 2'b00, 16'h0005, 0);
        cmd("p3",   1, 0, 0, 2'b00, 16'h0003, 0);
        cmd("add",  0, 1, 0, 2'b00, 16'h0000, 0);
        chk("add.lit_top", 32'(top), 32'h0008);

        // Sub with borrow, then recovery by push
        do_reset("rst2");
        cmd("p2",   1, 0, 0, 2'b00, 16'h0002, 0);
        cmd("p7",   1, 0, 0, 2'b00, 16'h0007, 0);
        cmd("sub",  0, 1, 0, 2'b01, 16'h0000, 0);
        chk("sub.lit_top", 32'(top), 32'hFFFB);
        cmd("p1",   1, 0, 0, 2'b00, 16'h0001, 0);

        // Overflow
        do_reset("rst3");
        for (int i = 1; i <= 5; i++) cmd($sformatf("fill%0d", i), 1, 0, 0, 2'b00, 16'(i), 0);
        chk("ovf.lit_top", 32'(top), 32'h0004);

        // Underflow on empty stack
        do_reset("rst4");
        cmd("op_empty",  0, 1, 0, 2'b00, 16'h0000, 0);
        cmd("pop_empty", 0, 0, 1, 2'b00, 16'h0000, 0);

        // Priority, ignored commands during EXEC, logic ops, pop
        cmd("push_pop",  1, 0, 1, 2'b00, 16'h00F0, 0);
        cmd("p0f0f",     1, 0, 0, 2'b00, 16'h0F0F, 0);
        cmd("and_poke",  0, 1, 0, 2'b10, 16'h0000, 1);
        cmd("pf000",     1, 0, 0, 2'b00, 16'hF000, 0);
        cmd("or",        0, 1, 0, 2'b11, 16'h0000, 0);
        cmd("op_pop",    0, 1, 1, 2'b10, 16'h0000, 0);
        cmd("p8000a",    1, 0, 0, 2'b00, 16'h8000, 0);
        cmd("p8000b",    1, 0, 0, 2'b00, 16'h8000, 0);
        cmd("add_carry", 0, 1, 0, 2'b00, 16'h0000, 0);
        cmd("pop1",      0, 0, 1, 2'b00, 16'h0000, 0);
        cmd("pop2",      0, 0, 1, 2'b00, 16'h0000, 0);

        // Asynchronous reset while EXEC is pending
        do_reset("rst6");
        cmd("pffff", 1, 0, 0, 2'b00, 16'hFFFF, 0);
        cmd("p0001", 1, 0, 0, 2'b00, 16'h0001, 0);
        @(negedge clk);
        op_go = 1; op_sel = 2'b00;
        @(posedge clk);
        #1;
        op_go = 0;
        chk("midexec.state", 32'(state_num), 32'd1);
        rst = 1'b1;
        #1;
        mstk.delete();
        m_ovf = 0; m_unf = 0; m_ari = 0; m_sn = 0;
        model_expect();
        compare("midexec_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_expect();
        compare("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Parametrised RPN operand stack with integrated ALU sequencing for the calculator datapath.
- Replaces the fixed A/B/op register-bank capture. Switch values are pushed onto a stack of DEPTH entries; an operation consumes the top two entries and pushes the result.
- Sits between the debounced button pulses and switch inputs on one side, and the hex2dec/display path on the other.

Parameters:
- BITS, 16, operand/result width.
- DEPTH, 4, number of stack entries (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- operand  input  BITS  value pushed on push.
- push  input  1  one-cycle pulse: push operand.
- op_go  input  1  one-cycle pulse: execute op_sel on the top two entries.
- op_sel  input  2  00 add, 01 sub (second minus top), 10 AND, 11 OR.
- pop  input  1  one-cycle pulse: discard top entry (undo).
- top  output  BITS  entry at stack top; 0 when empty.
- second  output  BITS  entry below top; 0 when depth<2.
- depth  output  $clog2(DEPTH+1)  number of valid entries.
- full  output  1  depth==DEPTH.
- empty  output  1  depth==0.
- ovf_err  output  1  sticky: push attempted while full.
- unf_err  output  1  sticky: op_go with depth<2, or pop with depth==0.
- arith_err  output  1  sticky: add carry-out or sub borrow on the last executed op.
- state_num  output  4  display code: 0 idle, 1 executing, 2 error.

Behaviour:
- Reset (async, any time, including mid-EXEC): depth=0, all entries 0, top=second=0, all error flags 0, state IDLE, state_num=0.
- All outputs are registered and reflect an accepted command the cycle after the accepting edge, except op results (below).
- States:
  - IDLE: accepts commands.
  - EXEC: one cycle; writes the result.
  - ERR: entered when any error flag sets.
- Command priority within one cycle: push > op_go > pop. Lower-priority pulses in the same cycle are dropped, not queued.
- IDLE, push:
  - depth<DEPTH: entry[depth]=operand, depth+1.
  - full: stack unchanged, ovf_err=1, go to ERR.
- IDLE, pop:
  - depth>0: depth-1; the vacated entry is cleared to 0.
  - empty: unf_err=1, go to ERR.
- IDLE, op_go:
  - depth<2: stack unchanged, unf_err=1, go to ERR.
  - otherwise latch A=second, B=top, go to EXEC.
- EXEC:
  - Result R = A op B, truncated to BITS.
  - Add: arith_err=carry-out. Sub: arith_err=(A<B).
  - Entry[depth-2]=R, entry[depth-1]=0, depth-1, then back to IDLE, or to ERR if arith_err was set.
  - Op latency: op_go edge -> result visible on top 2 cycles later.
  - Any push/pop/op_go arriving during EXEC is ignored.
- ERR:
  - Stack contents remain valid and displayed.
  - push, pop and op_go are accepted exactly as in IDLE. Any accepted command clears all three error flags and returns to IDLE, unless that command itself raises a new error (stay in ERR with only the new flag set).
  - state_num=2 while in ERR.
- Wrap-around: sub producing a negative value wraps mod 2^BITS. There is no sign extension.
- depth never exceeds DEPTH and never underflows below 0.

Test Plan:
- Reset then push 0x0005, push 0x0003, op_go op_sel=00 -> 2 cycles after op_go: top=0x0008, depth=1, second=0, arith_err=0, state_num=0.
- Push 0x0002, push 0x0007, op_go op_sel=01 -> top=0xFFFB, depth=1, arith_err=1, state_num=2. Next push 0x0001 -> flags clear, depth=2, state_num=0.
- Push five values 1..5 with DEPTH=4 -> depth=4, full=1, top=0x0004, ovf_err=1 after the fifth push; stack unchanged.
- Empty stack: op_go -> unf_err=1, depth=0. pop -> unf_err stays 1, depth=0.
- Push 0x00F0 and pop asserted in the same cycle -> push wins: depth=1, top=0x00F0. op_go pulsed during EXEC -> ignored, depth decrements only once.
- Push 0xFFFF, push 0x0001, op_go add; assert rst during EXEC -> next cycle depth=0, top=0, all flags 0, state_num=0.
